// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/busy/done handshake and operand/result bundle for the divider
//
// Purpose: groups the handshake, operand and result signals between a
//   controlling sequencer (master) and seq_restoring_divider (slave).
// Signals:
//   start        master->slave  request a division, sampled only while busy=0
//   dividend     master->slave  N-bit unsigned dividend
//   divisor      master->slave  N-bit unsigned divisor
//   busy         slave->master  operation in progress (accept+1 through done cycle)
//   done         slave->master  one-cycle pulse, results just updated
//   quotient     slave->master  N-bit quotient, held until next completion
//   remainder    slave->master  N-bit remainder, held until next completion
//   div_by_zero  slave->master  divisor was zero for the result on the outputs

interface seq_restoring_divider_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle shift-subtract-restore unsigned divider
//
// Purpose: computes dividend / divisor one quotient bit per clock, using
//   n_bit_adder (B inverted, carry_in=1) as the trial subtractor.
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   - a zero divisor skips the iterations (latency 1) and raises div_by_zero
//   undefined - a zero divisor runs all N iterations; div_by_zero is tied to 0
// Modules:
//   n_bit_adder           - N-bit adder with carry in/out
//     a, b       in  N   addends
//     carry_in   in  1   carry into bit 0
//     sum        out N   a + b + carry_in, low N bits
//     carry_out  out 1   carry out of bit N-1
//   seq_restoring_divider - the divider
//     clk        in  1   rising-edge clock
//     rst_n      in  1   asynchronous active-low reset
//     bus        slave modport of seq_restoring_divider_if (start/operands/busy/done/results)

module n_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  // Ripple chain, one full adder per bit.
  logic [N:0] c;

  always_comb begin
    c[0] = carry_in;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out = c[N];
endmodule

module seq_restoring_divider #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  q_reg;        // dividend shifting out the top, quotient bits shifting in
  logic [N:0]    r_reg;        // partial remainder
  logic [N-1:0]  divisor_reg;
  logic [CW-1:0] count;

  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  quotient_r;
  logic [N-1:0]  remainder_r;

  logic [N:0]    trial_a;
  logic [N:0]    trial_b;
  logic [N:0]    trial_t;
  logic          no_borrow;
  logic [N:0]    r_next;
  logic [N-1:0]  q_next;

  // The partial remainder always stays below the divisor, so its top bit
  // never feeds the next trial; it is kept only for the full-width register.
  logic          unused_r_msb;
  assign unused_r_msb = r_reg[N];

  // Trial subtraction: shifted remainder minus zero-extended divisor.
  assign trial_a = {r_reg[N-1:0], q_reg[N-1]};
  assign trial_b = ~{1'b0, divisor_reg};

  n_bit_adder #(.N(N + 1)) u_sub (
    .a         (trial_a),
    .b         (trial_b),
    .carry_in  (1'b1),
    .sum       (trial_t),
    .carry_out (no_borrow)
  );

  // carry_out=1 means no borrow: keep the difference; otherwise restore.
  assign r_next = no_borrow ? trial_t : trial_a;
  assign q_next = {q_reg[N-2:0], no_borrow};

`ifdef DIV_ZERO_DETECT_EN
  logic zero_op;
  logic dbz_r;
  assign bus.div_by_zero = dbz_r;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      divisor_reg <= '0;
      count       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
`ifdef DIV_ZERO_DETECT_EN
      zero_op     <= 1'b0;
      dbz_r       <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            divisor_reg <= bus.divisor;
            q_reg       <= bus.dividend;
            r_reg       <= '0;
            count       <= '0;
            busy_r      <= 1'b1;
            state       <= CALC;
`ifdef DIV_ZERO_DETECT_EN
            zero_op     <= (bus.divisor == '0);
`endif
          end
        end

        CALC: begin
`ifdef DIV_ZERO_DETECT_EN
          if (zero_op) begin
            // q_reg still holds the untouched dividend here.
            quotient_r  <= '1;
            remainder_r <= q_reg;
            dbz_r       <= 1'b1;
            done_r      <= 1'b1;
            state       <= DONE;
          end else
`endif
          begin
            r_reg <= r_next;
            q_reg <= q_next;
            count <= count + CW'(1);
            if (count == CW'(N - 1)) begin
              quotient_r  <= q_next;
              remainder_r <= r_next[N-1:0];
              done_r      <= 1'b1;
              state       <= DONE;
`ifdef DIV_ZERO_DETECT_EN
              dbz_r       <= 1'b0;
`endif
            end
          end
        end

        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider

module tb_seq_restoring_divider;
  localparam int N = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.N(N)) bus ();

  seq_restoring_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic int exp_q(input int a, input int b);
    return (b == 0) ? (1 << N) - 1 : a / b;
  endfunction

  function automatic int exp_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int exp_lat(input int b);
    return (DZ && b == 0) ? 1 : N;
  endfunction

  function automatic int exp_dz(input int b);
    return (DZ && b == 0) ? 1 : 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation; inject >= 0 re-pulses start with 50/5 that many cycles after accept.
  task automatic run_op(input int a, input int b, input int inject);
    int cyc;
    logic [N-1:0] pq, pr;
    bit stable;
    pq = bus.quotient;
    pr = bus.remainder;
    stable = 1'b1;
    bus.dividend = N'(a);
    bus.divisor  = N'(b);
    bus.start    = 1'b1;
    tick;
    bus.start = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.quotient !== pq || bus.remainder !== pr) stable = 1'b0;
      if (cyc == inject) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
      end else begin
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
      end
      tick;
      cyc++;
    end
    bus.start = 1'b0;
    check($sformatf("latency %0d/%0d", a, b), cyc, exp_lat(b));
    check("outputs_held_until_done", stable, 1);
    check($sformatf("quotient %0d/%0d", a, b), bus.quotient, exp_q(a, b));
    check($sformatf("remainder %0d/%0d", a, b), bus.remainder, exp_r(a, b));
    check($sformatf("div_by_zero %0d/%0d", a, b), bus.div_by_zero, exp_dz(b));
    check("busy_at_done", bus.busy, 1);
    tick;
    check("done_one_cycle", bus.done, 0);
    check("busy_drops_after_done", bus.busy, 0);
    tick;
    check("no_queued_start", bus.busy, 0);
  endtask

  task automatic back_to_back(input int nops);
    int cyc, acc_cnt, done_cnt, unstable;
    int acc_edge, pa, pb;
    logic [N-1:0] lq, lr;
    cyc = 0; acc_cnt = 0; done_cnt = 0; unstable = 0;
    acc_edge = 0; pa = 0; pb = 1;
    lq = bus.quotient;
    lr = bus.remainder;
    bus.start    = 1'b1;
    bus.dividend = N'($urandom);
    bus.divisor  = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
    while (done_cnt < nops && cyc < nops * 12 + 100) begin
      // cyc is the index of the edge about to occur
      if (!bus.busy) begin
        if (acc_cnt > 0) check("accept_spacing", cyc - acc_edge, exp_lat(pb) + 2);
        pa = int'(bus.dividend);
        pb = int'(bus.divisor);
        acc_edge = cyc;
        acc_cnt++;
      end
      tick;
      cyc++;
      bus.dividend = N'($urandom);
      bus.divisor  = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
      if (bus.done) begin
        check("b2b_latency", (cyc - 1) - acc_edge, exp_lat(pb));
        check($sformatf("b2b_quotient %0d/%0d", pa, pb), bus.quotient, exp_q(pa, pb));
        check($sformatf("b2b_remainder %0d/%0d", pa, pb), bus.remainder, exp_r(pa, pb));
        check("b2b_div_by_zero", bus.div_by_zero, exp_dz(pb));
        lq = bus.quotient;
        lr = bus.remainder;
        done_cnt++;
      end else if (bus.quotient !== lq || bus.remainder !== lr) begin
        unstable++;
      end
    end
    bus.start = 1'b0;
    check("b2b_ops_completed", done_cnt, nops);
    check("b2b_outputs_stable", unstable, 0);
  endtask

  initial begin
    int seen;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_div_by_zero", bus.div_by_zero, 0);
    rst_n = 1'b1;
    tick;

    run_op(100, 7, -1);
    run_op(5, 9, -1);
    run_op(255, 1, -1);
    run_op(255, 255, -1);
    run_op(200, 0, -1);
    run_op(0, 3, -1);
    run_op(100, 7, 3);
    run_op(50, 5, -1);

    // Reset in the middle of a calculation.
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (3) tick;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", bus.busy, 0);
    check("midreset_done", bus.done, 0);
    check("midreset_quotient", bus.quotient, 0);
    check("midreset_remainder", bus.remainder, 0);
    check("midreset_div_by_zero", bus.div_by_zero, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick;
      if (bus.done) seen = 1;
    end
    check("midreset_no_done", seen, 0);
    run_op(9, 2, -1);

    back_to_back(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
